// File: rtl/vit_pkg.sv
// Shared definitions for the Viterbi front-end: loader states, packing
// geometry and default widths.
package vit_pkg;

   localparam int DEF_ADDR_W        = 12;
   localparam int DEF_CNT_W         = 14;
   localparam int SOFTBITS_PER_WORD = 3;

   localparam logic [7:0] ERASURE = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_FLUSH,
      ST_KICK,
      ST_WAIT_DONE
   } loader_state_t;

endpackage

// File: rtl/vit_frame_loader_if.sv
// Bundle of the frame loader's control, soft-bit stream, SRAM write and
// core handshake signals. The slave side is the loader itself.
interface vit_frame_loader_if
   import vit_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = DEF_CNT_W
) ();

   logic              load_start;
   logic [CNT_W-1:0]  softbit_count;
   logic [ADDR_W-1:0] start_addr;
   logic              s_valid;
   logic [7:0]        s_data;
   logic              s_ready;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [23:0]       mem_wdata;
   logic              frame_start;
   logic              frame_done;
   logic              busy;
   logic [ADDR_W:0]   words;

   modport master (
      output load_start, softbit_count, start_addr, s_valid, s_data, frame_done,
      input  s_ready, mem_wr, mem_addr, mem_wdata, frame_start, busy, words
   );

   modport slave (
      input  load_start, softbit_count, start_addr, s_valid, s_data, frame_done,
      output s_ready, mem_wr, mem_addr, mem_wdata, frame_start, busy, words
   );

endinterface

// File: rtl/vit_sb_packer.sv
// Packs accepted signed soft bits three to a 24-bit word, padding a short
// final word with erasures. Emits a one-cycle registered word strobe.
module vit_sb_packer
   import vit_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear,
   input  logic        accept,
   input  logic        last,
   input  logic [7:0]  data,
   output logic        word_valid,
   output logic [23:0] word
);

   localparam logic [1:0] LAST_LANE = 2'(SOFTBITS_PER_WORD - 1);

   logic [1:0]  idx_q;
   logic [7:0]  lane0_q;
   logic [7:0]  lane1_q;
   logic        valid_q;
   logic [23:0] word_q;
   logic        commit;
   logic [23:0] word_c;

   // Build the outgoing word: the arriving beat fills its lane, later lanes read as erasures
   always_comb begin
      word_c = {ERASURE, ERASURE, ERASURE};
      commit = accept && ((idx_q == LAST_LANE) || last);
      case (idx_q)
         2'd0:    word_c = {ERASURE, ERASURE, data};
         2'd1:    word_c = {ERASURE, data, lane0_q};
         default: word_c = {data, lane1_q, lane0_q};
      endcase
   end

   // Lane storage, lane index and the registered word strobe
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q   <= 2'd0;
         lane0_q <= ERASURE;
         lane1_q <= ERASURE;
         valid_q <= 1'b0;
         word_q  <= 24'd0;
      end else if (clear) begin
         idx_q   <= 2'd0;
         lane0_q <= ERASURE;
         lane1_q <= ERASURE;
         valid_q <= 1'b0;
         word_q  <= 24'd0;
      end else begin
         valid_q <= commit;
         if (commit) begin
            word_q  <= word_c;
            idx_q   <= 2'd0;
            lane0_q <= ERASURE;
            lane1_q <= ERASURE;
         end else if (accept) begin
            if (idx_q == 2'd0) lane0_q <= data;
            else               lane1_q <= data;
            idx_q <= idx_q + 2'd1;
         end
      end
   end

   assign word_valid = valid_q;
   assign word       = word_q;

endmodule

// File: rtl/vit_frame_loader.sv
// Frame loader in front of viterbi_core: streams a frame of soft bits into
// the input SRAM, kicks the core, then waits for it to finish.
module vit_frame_loader
   import vit_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               rst_sync_i,
   vit_frame_loader_if.slave  bus
);

   loader_state_t state_q, state_n;

   logic [CNT_W-1:0]  remain_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   words_q;
   logic              ready_q;
   logic              busy_q;
   logic              kick_q;
   logic              accept;
   logic              last;
   logic              start_ok;
   logic              word_valid;
   logic [23:0]       word;

   assign start_ok = (state_q == ST_IDLE) && bus.load_start && (bus.softbit_count != '0);
   assign accept   = bus.s_valid && ready_q;
   assign last     = (remain_q == CNT_W'(1));

   // Next-state selection for the load / kick / wait sequence
   always_comb begin
      state_n = state_q;
      case (state_q)
         ST_IDLE:      if (start_ok) state_n = ST_FILL;
         ST_FILL:      if (accept && last) state_n = ST_FLUSH;
         ST_FLUSH:     state_n = ST_KICK;
         ST_KICK:      state_n = ST_WAIT_DONE;
         ST_WAIT_DONE: if (bus.frame_done) state_n = ST_IDLE;
         default:      state_n = ST_IDLE;
      endcase
   end

   // State register and registered handshake outputs derived from it
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         kick_q  <= 1'b0;
      end else if (rst_sync_i) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         kick_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         ready_q <= (state_n == ST_FILL);
         busy_q  <= (state_n != ST_IDLE);
         kick_q  <= (state_q == ST_KICK);
      end
   end

   // Remaining count, write address (advanced as each word retires) and word tally
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         remain_q <= '0;
         addr_q   <= '0;
         words_q  <= '0;
      end else if (rst_sync_i) begin
         remain_q <= '0;
         addr_q   <= '0;
         words_q  <= '0;
      end else if (start_ok) begin
         remain_q <= bus.softbit_count;
         addr_q   <= bus.start_addr;
         words_q  <= '0;
      end else begin
         if (accept) remain_q <= remain_q - CNT_W'(1);
         if (word_valid) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (words_q != '1) words_q <= words_q + (ADDR_W+1)'(1);
         end
      end
   end

   vit_sb_packer u_packer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear      (rst_sync_i || start_ok),
      .accept     (accept),
      .last       (last),
      .data       (bus.s_data),
      .word_valid (word_valid),
      .word       (word)
   );

   assign bus.s_ready     = ready_q;
   assign bus.mem_wr      = word_valid;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_wdata   = word;
   assign bus.frame_start = kick_q;
   assign bus.busy        = busy_q;
   assign bus.words       = words_q;

endmodule

// File: tb/tb_vit_frame_loader.sv
// Self-checking bench for vit_frame_loader: random soft-bit frames compared
// against a packing model built from the frame contents.
module tb_vit_frame_loader;

   localparam int ADDR_W = 12;
   localparam int CNT_W  = 14;

   logic clk_i = 1'b0;
   logic rst_i;
   logic rst_sync_i;

   int n_asserts = 0;
   int n_fails   = 0;
   int cyc       = 0;

   logic [ADDR_W-1:0] got_addr[$];
   logic [23:0]       got_data[$];
   int                wr_cyc[$];
   int                kick_cyc[$];
   logic [ADDR_W-1:0] exp_addr[$];
   logic [23:0]       exp_data[$];

   vit_frame_loader_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   vit_frame_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rst_sync_i (rst_sync_i),
      .bus        (bus)
   );

   // Free-running clock
   always #5 clk_i = ~clk_i;

   // Cycle index used to time writes against the kick
   always @(posedge clk_i) cyc <= cyc + 1;

   // Record every SRAM write and frame kick mid-cycle
   always @(negedge clk_i) begin
      if (bus.mem_wr === 1'b1) begin
         got_addr.push_back(bus.mem_addr);
         got_data.push_back(bus.mem_wdata);
         wr_cyc.push_back(cyc);
      end
      if (bus.frame_start === 1'b1) kick_cyc.push_back(cyc);
   end

   // Drives one whole frame, builds the expected write list, and returns observations
   task automatic run_frame(input int count, input int addr, input int stall_pct,
                            input bit seq_data, input bit early_done, input bit extra_start,
                            output int ready_low, output int words_seen, output int busy_mid,
                            output int busy_after, output int ready_wait, output int kick_gap,
                            output bit timeout);
      logic [7:0] sb[$];
      logic [23:0] w;
      int idx, guard;
      logic rdy;
      bit done_sent;
      sb.delete();
      exp_addr.delete(); exp_data.delete();
      got_addr.delete(); got_data.delete(); wr_cyc.delete(); kick_cyc.delete();
      for (int i = 0; i < count; i++) sb.push_back(seq_data ? 8'(i + 1) : 8'($urandom));
      for (int k = 0; k < (count + 2) / 3; k++) begin
         w = 24'd0;
         for (int l = 0; l < 3; l++)
            if (3 * k + l < count) w = w | (24'(sb[3 * k + l]) << (8 * l));
         exp_addr.push_back(ADDR_W'((addr + k) % 4096));
         exp_data.push_back(w);
      end
      ready_low = 0; timeout = 0; done_sent = 0;
      bus.load_start    = 1'b1;
      bus.softbit_count = CNT_W'(count);
      bus.start_addr    = ADDR_W'(addr);
      @(posedge clk_i); #1;
      bus.load_start    = 1'b0;
      bus.softbit_count = CNT_W'($urandom);
      bus.start_addr    = ADDR_W'($urandom);
      busy_mid = int'(bus.busy);
      idx = 0; guard = 0;
      while (idx < count && guard < count * 20 + 100) begin
         bus.s_valid = ($urandom_range(99) >= stall_pct);
         bus.s_data  = sb[idx];
         if (early_done && !done_sent && idx >= count / 2) begin
            bus.frame_done = 1'b1;
            done_sent = 1'b1;
         end else begin
            bus.frame_done = 1'b0;
         end
         @(negedge clk_i);
         rdy = bus.s_ready;
         if (rdy !== 1'b1) ready_low++;
         @(posedge clk_i); #1;
         if (bus.s_valid && rdy === 1'b1) idx++;
         guard++;
      end
      bus.s_valid = 1'b0;
      bus.frame_done = 1'b0;
      if (idx < count) timeout = 1'b1;
      guard = 0;
      while (kick_cyc.size() == 0 && guard < 50) begin
         @(posedge clk_i); #1;
         guard++;
      end
      if (kick_cyc.size() == 0) timeout = 1'b1;
      if (extra_start) begin
         bus.load_start    = 1'b1;
         bus.softbit_count = CNT_W'(30);
         bus.start_addr    = ADDR_W'(12'h555);
         @(posedge clk_i); #1;
         bus.load_start = 1'b0;
      end
      repeat (3) @(posedge clk_i);
      #1;
      ready_wait = int'(bus.s_ready);
      words_seen = int'(bus.words);
      kick_gap = (kick_cyc.size() > 0 && wr_cyc.size() > 0) ? kick_cyc[0] - wr_cyc[$] : -1;
      bus.frame_done = 1'b1;
      @(posedge clk_i); #1;
      bus.frame_done = 1'b0;
      busy_after = int'(bus.busy);
   endtask

   task automatic test_reset();
      rst_i = 1'b1; rst_sync_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      n_asserts++; if (bus.s_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_s_ready got %b want 0", bus.s_ready); end
      n_asserts++; if (bus.mem_wr !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_mem_wr got %b want 0", bus.mem_wr); end
      n_asserts++; if (bus.mem_addr !== '0) begin n_fails++; $display("[TB] FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
      n_asserts++; if (bus.mem_wdata !== 24'd0) begin n_fails++; $display("[TB] FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); end
      n_asserts++; if (bus.frame_start !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_frame_start got %b want 0", bus.frame_start); end
      n_asserts++; if (bus.busy !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
      n_asserts++; if (bus.words !== '0) begin n_fails++; $display("[TB] FAIL reset_words got %h want 0", bus.words); end
      rst_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      n_asserts++; if (bus.s_ready !== 1'b0 || bus.busy !== 1'b0) begin n_fails++; $display("[TB] FAIL idle_after_reset ready %b busy %b want 0 0", bus.s_ready, bus.busy); end
   endtask

   task automatic test_exact_frame();
      int rl, ws, bm, ba, rw, kg; bit to;
      run_frame(192, 0, 0, 0, 0, 0, rl, ws, bm, ba, rw, kg, to);
      n_asserts++; if (to) begin n_fails++; $display("[TB] FAIL exact_timeout got 1 want 0"); end
      n_asserts++; if (got_addr.size() != 64) begin n_fails++; $display("[TB] FAIL exact_write_count got %0d want 64", got_addr.size()); end
      for (int k = 0; k < got_addr.size() && k < exp_addr.size(); k++) begin
         n_asserts++;
         if (got_addr[k] !== ADDR_W'(k) || got_data[k] !== exp_data[k]) begin
            n_fails++; $display("[TB] FAIL exact_word%0d got %h:%h want %h:%h", k, got_addr[k], got_data[k], k, exp_data[k]);
         end
      end
      n_asserts++; if (kg != 2) begin n_fails++; $display("[TB] FAIL exact_kick_gap got %0d want 2", kg); end
      n_asserts++; if (kick_cyc.size() != 1) begin n_fails++; $display("[TB] FAIL exact_kick_count got %0d want 1", kick_cyc.size()); end
      n_asserts++; if (ws != 64) begin n_fails++; $display("[TB] FAIL exact_words got %0d want 64", ws); end
      n_asserts++; if (bm != 1) begin n_fails++; $display("[TB] FAIL exact_busy_start got %0d want 1", bm); end
      n_asserts++; if (ba != 0) begin n_fails++; $display("[TB] FAIL exact_busy_done got %0d want 0", ba); end
      n_asserts++; if (rl != 0 || rw != 0) begin n_fails++; $display("[TB] FAIL exact_ready got fill_low %0d wait %0d want 0 0", rl, rw); end
   endtask

   task automatic test_partial_word();
      int rl, ws, bm, ba, rw, kg; bit to;
      run_frame(7, 16, 0, 1, 0, 0, rl, ws, bm, ba, rw, kg, to);
      n_asserts++; if (got_data.size() != 3) begin n_fails++; $display("[TB] FAIL partial_count got %0d want 3", got_data.size()); end
      if (got_data.size() == 3) begin
         n_asserts++; if (got_data[0] !== 24'h030201) begin n_fails++; $display("[TB] FAIL partial_w0 got %h want 030201", got_data[0]); end
         n_asserts++; if (got_data[1] !== 24'h060504) begin n_fails++; $display("[TB] FAIL partial_w1 got %h want 060504", got_data[1]); end
         n_asserts++; if (got_data[2] !== 24'h000007) begin n_fails++; $display("[TB] FAIL partial_w2 got %h want 000007", got_data[2]); end
         n_asserts++; if (got_addr[2] !== ADDR_W'(18)) begin n_fails++; $display("[TB] FAIL partial_addr got %h want 012", got_addr[2]); end
      end
      n_asserts++; if (ws != 3) begin n_fails++; $display("[TB] FAIL partial_words got %0d want 3", ws); end
      n_asserts++; if (kg != 2 || to) begin n_fails++; $display("[TB] FAIL partial_kick got gap %0d timeout %0d want 2 0", kg, to); end
   endtask

   task automatic test_wrap();
      int rl, ws, bm, ba, rw, kg; bit to;
      run_frame(9, 12'hFFE, 0, 0, 0, 0, rl, ws, bm, ba, rw, kg, to);
      n_asserts++; if (got_addr.size() != 3) begin n_fails++; $display("[TB] FAIL wrap_count got %0d want 3", got_addr.size()); end
      if (got_addr.size() == 3) begin
         n_asserts++; if (got_addr[0] !== 12'hFFE || got_addr[1] !== 12'hFFF || got_addr[2] !== 12'h000) begin
            n_fails++; $display("[TB] FAIL wrap_addr got %h %h %h want ffe fff 000", got_addr[0], got_addr[1], got_addr[2]);
         end
         for (int k = 0; k < 3; k++) begin
            n_asserts++; if (got_data[k] !== exp_data[k]) begin n_fails++; $display("[TB] FAIL wrap_data%0d got %h want %h", k, got_data[k], exp_data[k]); end
         end
      end
   endtask

   task automatic test_random_stalls();
      int rl, ws, bm, ba, rw, kg; bit to;
      run_frame(100, int'($urandom_range(4095)), 40, 0, 0, 0, rl, ws, bm, ba, rw, kg, to);
      n_asserts++; if (to) begin n_fails++; $display("[TB] FAIL stall_timeout got 1 want 0"); end
      n_asserts++; if (got_addr.size() != exp_addr.size()) begin n_fails++; $display("[TB] FAIL stall_count got %0d want %0d", got_addr.size(), exp_addr.size()); end
      for (int k = 0; k < got_addr.size() && k < exp_addr.size(); k++) begin
         n_asserts++;
         if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
            n_fails++; $display("[TB] FAIL stall_word%0d got %h:%h want %h:%h", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
         end
      end
      n_asserts++; if (rl != 0) begin n_fails++; $display("[TB] FAIL stall_ready_fill got %0d low cycles want 0", rl); end
      n_asserts++; if (rw != 0) begin n_fails++; $display("[TB] FAIL stall_ready_wait got %0d want 0", rw); end
      n_asserts++; if (ws != 34 || kg != 2) begin n_fails++; $display("[TB] FAIL stall_words_kick got %0d/%0d want 34/2", ws, kg); end
   endtask

   task automatic test_ignored_events();
      int rl, ws, bm, ba, rw, kg, n; bit to;
      n = int'($urandom_range(60, 20));
      run_frame(n, int'($urandom_range(4095)), 20, 0, 1, 1, rl, ws, bm, ba, rw, kg, to);
      n_asserts++; if (to) begin n_fails++; $display("[TB] FAIL ignore_timeout got 1 want 0"); end
      n_asserts++; if (got_addr.size() != exp_addr.size()) begin n_fails++; $display("[TB] FAIL ignore_count got %0d want %0d", got_addr.size(), exp_addr.size()); end
      for (int k = 0; k < got_addr.size() && k < exp_addr.size(); k++) begin
         n_asserts++;
         if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
            n_fails++; $display("[TB] FAIL ignore_word%0d got %h:%h want %h:%h", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
         end
      end
      n_asserts++; if (kick_cyc.size() != 1 || kg != 2) begin n_fails++; $display("[TB] FAIL ignore_kick got %0d kicks gap %0d want 1 2", kick_cyc.size(), kg); end
      n_asserts++; if (rw != 0 || ba != 0) begin n_fails++; $display("[TB] FAIL ignore_late_start got ready %0d busy %0d want 0 0", rw, ba); end
      repeat (10) @(posedge clk_i);
      #1;
      n_asserts++; if (got_addr.size() != exp_addr.size() || bus.s_ready !== 1'b0) begin
         n_fails++; $display("[TB] FAIL ignore_quiet got writes %0d ready %b want %0d 0", got_addr.size(), bus.s_ready, exp_addr.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      int rl, ws, bm, ba, rw, kg, acc, guard; bit to;
      logic [7:0] d[4];
      logic rdy;
      got_addr.delete(); got_data.delete(); wr_cyc.delete(); kick_cyc.delete();
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      bus.load_start = 1'b1; bus.softbit_count = CNT_W'(12); bus.start_addr = ADDR_W'(12'h040);
      @(posedge clk_i); #1;
      bus.load_start = 1'b0;
      acc = 0; guard = 0;
      while (acc < 4 && guard < 40) begin
         bus.s_valid = 1'b1; bus.s_data = d[acc];
         @(negedge clk_i); rdy = bus.s_ready;
         @(posedge clk_i); #1;
         if (rdy === 1'b1) acc++;
         guard++;
      end
      bus.s_valid = 1'b0;
      rst_sync_i = 1'b1;
      @(posedge clk_i); #1;
      rst_sync_i = 1'b0;
      n_asserts++; if (bus.busy !== 1'b0) begin n_fails++; $display("[TB] FAIL rstmid_busy got %b want 0", bus.busy); end
      repeat (10) @(posedge clk_i);
      #1;
      n_asserts++; if (got_addr.size() != 1) begin n_fails++; $display("[TB] FAIL rstmid_writes got %0d want 1", got_addr.size()); end
      if (got_addr.size() == 1) begin
         n_asserts++; if (got_addr[0] !== 12'h040 || got_data[0] !== {d[2], d[1], d[0]}) begin
            n_fails++; $display("[TB] FAIL rstmid_word got %h:%h want 040:%h", got_addr[0], got_data[0], {d[2], d[1], d[0]});
         end
      end
      n_asserts++; if (kick_cyc.size() != 0) begin n_fails++; $display("[TB] FAIL rstmid_kick got %0d want 0", kick_cyc.size()); end
      run_frame(5, 12'h123, 0, 0, 0, 0, rl, ws, bm, ba, rw, kg, to);
      n_asserts++; if (got_addr.size() != 2 || to) begin n_fails++; $display("[TB] FAIL rstmid_reload_count got %0d want 2", got_addr.size()); end
      for (int k = 0; k < got_addr.size() && k < exp_addr.size(); k++) begin
         n_asserts++;
         if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
            n_fails++; $display("[TB] FAIL rstmid_reload%0d got %h:%h want %h:%h", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int rl, ws, bm, ba, rw, kg; bit to;
      for (int f = 0; f < 2; f++) begin
         run_frame(int'($urandom_range(40, 1)), int'($urandom_range(4095)), 10, 0, 0, 0, rl, ws, bm, ba, rw, kg, to);
         n_asserts++; if (to || bm != 1) begin n_fails++; $display("[TB] FAIL b2b%0d_start got timeout %0d busy %0d want 0 1", f, to, bm); end
         n_asserts++; if (got_addr.size() != exp_addr.size() || ws != exp_addr.size()) begin
            n_fails++; $display("[TB] FAIL b2b%0d_count got %0d words %0d want %0d", f, got_addr.size(), ws, exp_addr.size());
         end
         for (int k = 0; k < got_addr.size() && k < exp_addr.size(); k++) begin
            n_asserts++;
            if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
               n_fails++; $display("[TB] FAIL b2b%0d_word%0d got %h:%h want %h:%h", f, k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
            end
         end
      end
   endtask

   // Test sequence
   initial begin
      rst_i = 1'b1; rst_sync_i = 1'b0;
      bus.load_start = 1'b0; bus.softbit_count = '0; bus.start_addr = '0;
      bus.s_valid = 1'b0; bus.s_data = 8'd0; bus.frame_done = 1'b0;
      test_reset();
      test_exact_frame();
      test_partial_word();
      test_wrap();
      test_random_stalls();
      test_ignored_events();
      test_reset_mid_frame();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

   // Hard time limit so a stuck design cannot hang the run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
